switch_ingress_fifo: RTL and testbench

Ingress buffer that sits directly upstream of the address-routing switch and drives its `vld`/`addr`/`data` inputs. It absorbs bursts from the traffic source in a DEPTH-entry FIFO and presents one address/data word per cycle to the switch when the switch can take it. It also counts words lost to overflow. The switch routes each presented word to port A or port B by address; this block does no routing.

---
 rtl/switch_ingress_fifo.sv | 133 +++++++++++++
 tb/tb_switch_ingress_fifo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_ingress_fifo.sv
// switch_ingress_fifo
//
// Ingress buffer in front of the address-routing switch. Words from the
// traffic source are absorbed in a DEPTH-entry circular buffer. The word at the
// head is presented to the switch one word per cycle, with show-ahead timing.
// Words offered while the buffer is full are discarded and counted.
//
// Ports
//   clk          single clock, rising edge
//   rstn         synchronous active-low reset
//   in_vld       source presents a word
//   in_addr      source address          [ADDR_WIDTH]
//   in_data      source data             [DATA_WIDTH]
//   in_rdy       buffer can accept a word this cycle
//   vld          head word presented to the switch
//   addr         head address (0 when vld = 0)
//   data         head data    (0 when vld = 0)
//   out_rdy      switch takes the presented word
//   count        occupancy, 0..DEPTH     [$clog2(DEPTH)+1]
//   almost_full  count >= DEPTH - AF_MARGIN
//   drop_cnt     saturating count of discarded words [16]
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high (in_vld/in_rdy on the source side, vld/out_rdy on the switch
// side). Valid never waits on ready. in_rdy and vld depend only on registered
// occupancy and rstn, so there is no combinational path from out_rdy to
// in_rdy. An in_vld seen with in_rdy low is a drop, not a stall.

module switch_ingress_fifo #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_vld,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_rdy,
  output logic                      vld,
  output logic [ADDR_WIDTH-1:0]     addr,
  output logic [DATA_WIDTH-1:0]     data,
  input  logic                      out_rdy,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      almost_full,
  output logic [15:0]               drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [15:0]   DROP_MAX = 16'hFFFF;

  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [WW-1:0] head;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign full  = (occ == DEPTH_C);
  assign empty = (occ == '0);

  // Gating with rstn keeps every handshake and the watermark quiet while the
  // block is held in reset, whatever state the registers hold.
  assign in_rdy      = rstn && !full;
  assign vld         = rstn && !empty;
  assign almost_full = rstn && (occ >= AF_LEVEL);

  // A full buffer refuses the word even if a pop frees a slot on the same
  // edge. The slot becomes usable on the following cycle.
  assign push = in_vld && in_rdy;
  assign pop  = vld && out_rdy;
  assign drop = rstn && in_vld && full;

  assign head = mem[rd_ptr];

  always_comb begin
    addr = '0;
    data = '0;
    if (vld) begin
      {addr, data} = head;
    end
  end

  assign count = occ;

  // Storage array: not reset, only the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_addr, in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_switch_ingress_fifo.sv
// Testbench for switch_ingress_fifo (default parameters: 8-bit addr,
// 16-bit data, 8 entries, almost_full margin 2).

module tb_switch_ingress_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 2;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rstn;
  logic        in_vld;
  logic [7:0]  in_addr;
  logic [15:0] in_data;
  logic        in_rdy;
  logic        vld;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        out_rdy;
  logic [3:0]  count;
  logic        almost_full;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  switch_ingress_fifo #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (16),
    .DEPTH      (DEPTH),
    .AF_MARGIN  (AF)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_vld      (in_vld),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .vld         (vld),
    .addr        (addr),
    .data        (data),
    .out_rdy     (out_rdy),
    .count       (count),
    .almost_full (almost_full),
    .drop_cnt    (drop_cnt)
  );

  // ---------------------------------------------------------------- counters
  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- scoreboard
  // Reference state advanced on every rising edge from the bench's own inputs.
  logic [23:0] exp_q[$];
  int          mc = 0;
  logic [15:0] md = 16'd0;
  int          pops_seen = 0;

  logic m_push;
  logic m_pop;
  logic m_drop;
  logic e_vld;
  logic e_rdy;
  logic e_af;

  assign m_push = in_vld && (mc != DEPTH);
  assign m_pop  = out_rdy && (mc != 0);
  assign m_drop = in_vld && (mc == DEPTH);
  assign e_vld  = rstn && (mc != 0);
  assign e_rdy  = rstn && (mc != DEPTH);
  assign e_af   = rstn && (mc >= DEPTH - AF);

  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      mc <= 0;
      md <= 16'd0;
    end else begin
      if (m_pop) begin
        void'(exp_q.pop_front());
        pops_seen <= pops_seen + 1;
      end
      if (m_push) begin
        exp_q.push_back({in_addr, in_data});
      end
      mc <= mc + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      if (m_drop && md != 16'hFFFF) begin
        md <= md + 16'd1;
      end
    end
  end

  // Monitor: compares every presented output against the reference on the
  // falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_in_rdy", in_rdy, e_rdy);
      check("mon_vld", vld, e_vld);
      check("mon_count", count, 32'(mc));
      check("mon_almost_full", almost_full, e_af);
      check("mon_drop_cnt", drop_cnt, md);
      if (e_vld && exp_q.size() > 0) begin
        check("mon_addr", addr, exp_q[0][23:16]);
        check("mon_data", data, exp_q[0][15:0]);
      end else begin
        check("mon_addr_idle", addr, 0);
        check("mon_data_idle", data, 0);
      end
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic v, input logic [7:0] a, input logic [15:0] d, input logic r);
    in_vld  = v;
    in_addr = a;
    in_data = d;
    out_rdy = r;
  endtask

  // Advance one clock; the caller ends up just after the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base_a, input logic [15:0] base_d);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, base_a + 8'(i), base_d + 16'(i), 1'b0);
      cycle();
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  // Watchdog bound on the whole run.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int k;
    int n;
    int pops_before;
    bit over;

    rstn = 1'b0;
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    cycle();
    mon_en = 1'b1;
    cycle();
    cycle();
    check("rst_vld", vld, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_af", almost_full, 0);
    check("rst_addr", addr, 0);
    check("rst_count", count, 0);
    rstn = 1'b1;
    #1;
    check("post_rst_in_rdy", in_rdy, 1);
    check("post_rst_drop", drop_cnt, 0);

    // Reset then single word
    drive(1'b1, 8'h12, 16'hBEEF, 1'b1);
    cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    check("single_vld", vld, 1);
    check("single_addr", addr, 32'h12);
    check("single_data", data, 32'hBEEF);
    cycle();
    check("single_gone_vld", vld, 0);
    check("single_gone_addr", addr, 0);
    check("single_gone_data", data, 0);
    check("single_gone_count", count, 0);

    // Fill to full, watermark, drops, ordered drain
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 16'h100 + 16'(i), 1'b0);
      cycle();
      if (i == 4) check("fill_af_low_at5", almost_full, 0);
      if (i == 5) check("fill_af_high_at6", almost_full, 1);
      if (i == 6) check("fill_in_rdy_at7", in_rdy, 1);
    end
    check("fill_count8", count, 8);
    check("fill_in_rdy_full", in_rdy, 0);
    drive(1'b1, 8'hAA, 16'hAAAA, 1'b0);
    cycle();
    cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    check("fill_drop2", drop_cnt, 2);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_addr", addr, 32'(i));
      check("drain_data", data, 32'h100 + 32'(i));
      cycle();
    end
    check("drain_empty", count, 0);
    check("drain_vld", vld, 0);

    // Simultaneous push/pop at full
    fill(8'h20, 16'h2000);
    drive(1'b1, 8'h30, 16'h3030, 1'b1);
    cycle();
    check("pp_full_count7", count, 7);
    check("pp_full_drop3", drop_cnt, 3);
    drive(1'b1, 8'h30, 16'h3030, 1'b0);
    cycle();
    check("pp_retry_count8", count, 8);
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      check("pp_drain_addr", addr, 32'h20 + 32'(i));
      cycle();
    end
    check("pp_last_addr", addr, 32'h30);
    check("pp_last_data", data, 32'h3030);
    cycle();
    check("pp_empty", count, 0);

    // Pointer wrap: 20 words, out_rdy toggling 1,0,...
    pops_before = pops_seen;
    over = 1'b0;
    k = 0;
    n = 0;
    while (k < 20 && n < 200) begin
      logic acc;
      drive(1'b1, 8'h40 + 8'(k), 16'h4000 + 16'(k), (n % 2) == 0);
      acc = (mc != DEPTH);
      cycle();
      if (count > 4'd8) over = 1'b1;
      if (acc) k++;
      n++;
    end
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    n = 0;
    while (mc != 0 && n < 20) begin
      cycle();
      n++;
    end
    check("wrap_sent", k, 20);
    check("wrap_received", pops_seen - pops_before, 20);
    check("wrap_never_over8", over, 0);
    check("wrap_empty", count, 0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h50 + 8'(i), 16'h5000 + 16'(i), 1'b0);
      cycle();
    end
    check("mid_count5", count, 5);
    rstn = 1'b0;
    drive(1'b1, 8'h60, 16'h6060, 1'b0);
    #1;
    check("mid_rst_vld", vld, 0);
    check("mid_rst_in_rdy", in_rdy, 0);
    cycle();
    check("mid_rst_vld2", vld, 0);
    check("mid_rst_in_rdy2", in_rdy, 0);
    cycle();
    rstn = 1'b1;
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    #1;
    check("mid_rel_count", count, 0);
    check("mid_rel_drop", drop_cnt, 0);
    check("mid_rel_in_rdy", in_rdy, 1);
    check("mid_rel_vld", vld, 0);
    drive(1'b1, 8'h61, 16'h6161, 1'b0);
    cycle();
    drive(1'b0, 8'h00, 16'h0000, 1'b1);
    check("mid_new_vld", vld, 1);
    check("mid_new_addr", addr, 32'h61);
    check("mid_new_data", data, 32'h6161);
    cycle();
    check("mid_new_empty", count, 0);

    // Drop counter saturation
    fill(8'h70, 16'h7000);
    mon_en = 1'b0;
    drive(1'b1, 8'h7F, 16'h7F7F, 1'b0);
    repeat (65534) cycle();
    check("sat_fffe", drop_cnt, 32'hFFFE);
    repeat (6) cycle();
    check("sat_ffff", drop_cnt, 32'hFFFF);
    check("sat_count", count, 8);
    drive(1'b0, 8'h00, 16'h0000, 1'b0);
    mon_en = 1'b1;
    cycle();
    cycle();
    check("sat_hold", drop_cnt, 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
